// File: rtl/credit_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : credit_sequencer_if
//  Description : Request and status bundle between a coin/vend front end
//                and the credit sequencer. The requester side is the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface credit_sequencer_if;
    // Requests, one-cycle pulses with their sampled operands
    logic       COIN;
    logic [3:0] COIN_VAL;
    logic       VEND;
    logic [3:0] PRICE;
    logic       REFUND;

    // Operands and strobe for the adder_sub display datapath
    logic [3:0] A;
    logic [3:0] B;
    logic       SUB;
    logic       ENTER;

    // Credit and status
    logic [3:0] credit;
    logic       busy;
    logic       dispense;
    logic       deny;
    logic       refund_pls;
    logic       ovf;
    logic [3:0] refund_val;

    modport master (
        output COIN, COIN_VAL, VEND, PRICE, REFUND,
        input  A, B, SUB, ENTER, credit, busy,
        input  dispense, deny, refund_pls, ovf, refund_val
    );

    modport slave (
        input  COIN, COIN_VAL, VEND, PRICE, REFUND,
        output A, B, SUB, ENTER, credit, busy,
        output dispense, deny, refund_pls, ovf, refund_val
    );
endinterface
`default_nettype wire

// File: rtl/credit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : credit_sequencer
//  Description : Stored-credit controller for a vending front end. Each
//                accepted request walks IDLE -> SETUP -> STROBE -> IDLE,
//                presenting its operands to the adder_sub display datapath
//                and committing the new credit as it leaves STROBE.
//  Revision    : 1.0 - initial release
// ============================================================================
module credit_sequencer #(
    parameter int CREDIT_MAX = 15
) (
    input  wire               clk,
    input  wire               CLR_n,
    credit_sequencer_if.slave bus
);

    // Saturation limit at the internal 5-bit and the visible 4-bit width
    localparam logic [4:0] c_MAX5 = 5'(CREDIT_MAX);
    localparam logic [3:0] c_MAX4 = 4'(CREDIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_STROBE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_COIN   = 2'b00,
        OP_VEND   = 2'b01,
        OP_REFUND = 2'b10
    } op_t;

    state_t     r_state;
    state_t     w_next;

    // Registered operands shown on the display, plus the operation in flight
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_sub;
    op_t        r_op;

    // Credit and status registers
    logic [3:0] r_credit;
    logic       r_dispense;
    logic       r_deny;
    logic       r_refund_pls;
    logic       r_ovf;
    logic [3:0] r_refund_val;

    // Decode of the request accepted this cycle
    logic       w_accept;
    op_t        w_op;
    logic [3:0] w_b_nxt;
    logic       w_sub_nxt;
    logic       w_deny_req;
    logic       w_busy;
    logic       w_enter;

    // Result of the operation in flight
    logic [4:0] w_sum;
    logic [4:0] w_diff;
    logic [3:0] w_new_credit;
    logic       w_ovf;

    // State register; reset aborts whatever operation is in flight
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, request arbitration (REFUND > VEND > COIN) and busy/ENTER
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_op       = OP_COIN;
        w_b_nxt    = bus.COIN_VAL;
        w_sub_nxt  = 1'b0;
        w_deny_req = 1'b0;
        w_busy     = 1'b0;
        w_enter    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.REFUND) begin
                    // B mirrors A so the display shows credit - credit = 0
                    w_accept  = 1'b1;
                    w_op      = OP_REFUND;
                    w_b_nxt   = r_credit;
                    w_sub_nxt = 1'b1;
                    w_next    = S_SETUP;
                end else if (bus.VEND) begin
                    if (r_credit >= bus.PRICE) begin
                        w_accept  = 1'b1;
                        w_op      = OP_VEND;
                        w_b_nxt   = bus.PRICE;
                        w_sub_nxt = 1'b1;
                        w_next    = S_SETUP;
                    end else begin
                        // Insufficient credit: answer at once, stay idle
                        w_deny_req = 1'b1;
                    end
                end else if (bus.COIN) begin
                    w_accept  = 1'b1;
                    w_op      = OP_COIN;
                    w_b_nxt   = bus.COIN_VAL;
                    w_sub_nxt = 1'b0;
                    w_next    = S_SETUP;
                end
            end
            S_SETUP: begin
                w_busy = 1'b1;
                w_next = S_STROBE;
            end
            S_STROBE: begin
                w_busy  = 1'b1;
                w_enter = 1'b1;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // New credit computed at 5 bits from the registered operands
    always_comb begin
        w_sum        = {1'b0, r_a} + {1'b0, r_b};
        w_diff       = {1'b0, r_a} - {1'b0, r_b};
        w_new_credit = r_credit;
        w_ovf        = 1'b0;
        case (r_op)
            OP_COIN: begin
                if (w_sum > c_MAX5) begin
                    w_new_credit = c_MAX4;
                    w_ovf        = 1'b1;
                end else begin
                    w_new_credit = w_sum[3:0];
                end
            end
            OP_VEND: begin
                // A vend is only accepted when credit covers the price;
                // clamp anyway so credit can never wrap.
                w_new_credit = w_diff[4] ? 4'd0 : w_diff[3:0];
            end
            OP_REFUND: begin
                w_new_credit = 4'd0;
            end
            default: begin
                w_new_credit = r_credit;
            end
        endcase
    end

    // Operand registers: loaded on acceptance, held otherwise for the display
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            r_a   <= 4'd0;
            r_b   <= 4'd0;
            r_sub <= 1'b0;
            r_op  <= OP_COIN;
        end else if (w_accept) begin
            r_a   <= r_credit;
            r_b   <= w_b_nxt;
            r_sub <= w_sub_nxt;
            r_op  <= w_op;
        end
    end

    // Credit commit and one-cycle status pulses as the sequence leaves STROBE
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            r_credit     <= 4'd0;
            r_dispense   <= 1'b0;
            r_deny       <= 1'b0;
            r_refund_pls <= 1'b0;
            r_ovf        <= 1'b0;
            r_refund_val <= 4'd0;
        end else begin
            r_dispense   <= 1'b0;
            r_deny       <= w_deny_req;
            r_refund_pls <= 1'b0;
            r_ovf        <= 1'b0;
            if (w_enter) begin
                r_credit <= w_new_credit;
                case (r_op)
                    OP_COIN: begin
                        r_ovf <= w_ovf;
                    end
                    OP_VEND: begin
                        r_dispense <= 1'b1;
                    end
                    OP_REFUND: begin
                        r_refund_pls <= 1'b1;
                        r_refund_val <= r_a;
                    end
                    default: begin
                        r_ovf <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.A          = r_a;
    assign bus.B          = r_b;
    assign bus.SUB        = r_sub;
    assign bus.ENTER      = w_enter;
    assign bus.credit     = r_credit;
    assign bus.busy       = w_busy;
    assign bus.dispense   = r_dispense;
    assign bus.deny       = r_deny;
    assign bus.refund_pls = r_refund_pls;
    assign bus.ovf        = r_ovf;
    assign bus.refund_val = r_refund_val;

endmodule
`default_nettype wire

// File: tb/tb_credit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_credit_sequencer
//  Description : Self-checking bench for credit_sequencer. A transaction
//                level model predicts every output each cycle; directed
//                vectors add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_sequencer;

    localparam int CREDIT_MAX = 15;

    logic clk = 1'b0;
    logic CLR_n;

    credit_sequencer_if bus ();

    credit_sequencer #(.CREDIT_MAX(CREDIT_MAX)) dut (
        .clk   (clk),
        .CLR_n (CLR_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: held values plus one pending transaction and its commit edge
    int cyc;
    int m_credit, m_a, m_b, m_sub, m_refval;
    bit m_pend;
    int m_acc, m_kind, m_new, m_ovf;
    int e_enter, e_busy, e_disp, e_deny, e_refp, e_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0; m_a = 0; m_b = 0; m_sub = 0; m_refval = 0;
        m_pend = 1'b0; m_acc = 0; m_kind = 0; m_new = 0; m_ovf = 0;
        e_enter = 0; e_busy = 0; e_disp = 0; e_deny = 0; e_refp = 0; e_ovf = 0;
    endtask

    task automatic model_start(input int kind, input int b, input int sub, input int newc);
        m_pend = 1'b1;
        m_acc  = cyc;
        m_kind = kind;
        m_a    = m_credit;
        m_b    = b;
        m_sub  = sub;
        m_new  = newc;
    endtask

    // Applies the request rules to what the DUT sees at the edge just passed
    task automatic model_edge();
        int sum;
        cyc++;
        e_enter = 0; e_busy = 0; e_disp = 0; e_deny = 0; e_refp = 0; e_ovf = 0;
        if (!CLR_n) begin
            model_reset();
        end else begin
            if (m_pend && cyc == m_acc + 2) begin
                m_pend   = 1'b0;
                m_credit = m_new;
                if (m_kind == 0) e_ovf = m_ovf;
                if (m_kind == 1) e_disp = 1;
                if (m_kind == 2) begin
                    e_refp   = 1;
                    m_refval = m_a;
                end
            end else if (!m_pend) begin
                if (bus.REFUND) begin
                    model_start(2, m_credit, 1, 0);
                end else if (bus.VEND) begin
                    if (m_credit >= int'(bus.PRICE))
                        model_start(1, int'(bus.PRICE), 1, m_credit - int'(bus.PRICE));
                    else
                        e_deny = 1;
                end else if (bus.COIN) begin
                    sum   = m_credit + int'(bus.COIN_VAL);
                    m_ovf = (sum > CREDIT_MAX) ? 1 : 0;
                    model_start(0, int'(bus.COIN_VAL), 0, (sum > CREDIT_MAX) ? CREDIT_MAX : sum);
                end
            end
            if (m_pend) begin
                e_busy  = 1;
                e_enter = (cyc == m_acc + 1) ? 1 : 0;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("credit",     32'(bus.credit),     m_credit);
            chk("A",          32'(bus.A),          m_a);
            chk("B",          32'(bus.B),          m_b);
            chk("SUB",        32'(bus.SUB),        m_sub);
            chk("ENTER",      32'(bus.ENTER),      e_enter);
            chk("busy",       32'(bus.busy),       e_busy);
            chk("dispense",   32'(bus.dispense),   e_disp);
            chk("deny",       32'(bus.deny),       e_deny);
            chk("refund_pls", 32'(bus.refund_pls), e_refp);
            chk("ovf",        32'(bus.ovf),        e_ovf);
            chk("refund_val", 32'(bus.refund_val), m_refval);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        bus.COIN   = 1'b0;
        bus.VEND   = 1'b0;
        bus.REFUND = 1'b0;
    endtask

    task automatic op(input bit c, input logic [3:0] cv, input bit v, input logic [3:0] p, input bit r);
        bus.COIN     = c;
        bus.COIN_VAL = cv;
        bus.VEND     = v;
        bus.PRICE    = p;
        bus.REFUND   = r;
        step();
    endtask

    initial begin
        CLR_n = 1'b1;
        bus.COIN = 1'b0; bus.COIN_VAL = 4'd0;
        bus.VEND = 1'b0; bus.PRICE = 4'd0; bus.REFUND = 1'b0;
        cyc = 0;
        model_reset();
        #2 CLR_n = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_credit", 32'(bus.credit), 0);
        chk("rst_busy",   32'(bus.busy),   0);
        chk("rst_A",      32'(bus.A),      0);

        // Release and coin 5 on the very next edge
        CLR_n = 1'b1;
        op(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk("c5_A", 32'(bus.A), 0); chk("c5_B", 32'(bus.B), 5);
        chk("c5_SUB", 32'(bus.SUB), 0); chk("c5_busy1", 32'(bus.busy), 1);
        step(); @(negedge clk);
        chk("c5_ENTER", 32'(bus.ENTER), 1); chk("c5_busy2", 32'(bus.busy), 1);
        step(); @(negedge clk);
        chk("c5_credit", 32'(bus.credit), 5); chk("c5_busy3", 32'(bus.busy), 0);

        // 5 + 7 = 12, then 12 + 6 saturates at 15 with ovf
        op(1'b1, 4'd7, 1'b0, 4'd0, 1'b0); step(); step();
        op(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk("c6_A", 32'(bus.A), 12); chk("c6_B", 32'(bus.B), 6);
        step(); step(); @(negedge clk);
        chk("c6_credit", 32'(bus.credit), 15); chk("c6_ovf", 32'(bus.ovf), 1);
        step(); @(negedge clk);
        chk("c6_ovf_1cyc", 32'(bus.ovf), 0);

        // Refund 15, coin 6, vend 5 -> 1, vend 8 denied with a dropped coin
        op(1'b0, 4'd0, 1'b0, 4'd0, 1'b1); step(); step(); @(negedge clk);
        chk("r15_val", 32'(bus.refund_val), 15); chk("r15_credit", 32'(bus.credit), 0);
        op(1'b1, 4'd6, 1'b0, 4'd0, 1'b0); step(); step();
        op(1'b0, 4'd0, 1'b1, 4'd5, 1'b0);
        @(negedge clk);
        chk("v5_A", 32'(bus.A), 6); chk("v5_B", 32'(bus.B), 5); chk("v5_SUB", 32'(bus.SUB), 1);
        step(); @(negedge clk);
        chk("v5_ENTER", 32'(bus.ENTER), 1);
        step(); @(negedge clk);
        chk("v5_credit", 32'(bus.credit), 1); chk("v5_disp", 32'(bus.dispense), 1);
        op(1'b1, 4'd3, 1'b1, 4'd8, 1'b0);
        @(negedge clk);
        chk("v8_deny", 32'(bus.deny), 1); chk("v8_busy", 32'(bus.busy), 0);
        chk("v8_credit", 32'(bus.credit), 1); chk("v8_A_held", 32'(bus.A), 6);
        step(); @(negedge clk);
        chk("v8_deny_1cyc", 32'(bus.deny), 0); chk("v8_credit2", 32'(bus.credit), 1);

        // Credit 7, all three requests at once: refund wins
        op(1'b1, 4'd6, 1'b0, 4'd0, 1'b0); step(); step();
        op(1'b1, 4'd2, 1'b1, 4'd3, 1'b1); step(); step(); @(negedge clk);
        chk("all_credit", 32'(bus.credit), 0); chk("all_rval", 32'(bus.refund_val), 7);
        chk("all_rpls", 32'(bus.refund_pls), 1); chk("all_disp", 32'(bus.dispense), 0);

        // Refund with zero credit still runs and pulses
        op(1'b0, 4'd0, 1'b0, 4'd0, 1'b1); step(); step(); @(negedge clk);
        chk("r0_rpls", 32'(bus.refund_pls), 1); chk("r0_rval", 32'(bus.refund_val), 0);

        // Coin 4; coin in SETUP and refund in STROBE are ignored
        op(1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        bus.COIN = 1'b1; bus.COIN_VAL = 4'd9; step();
        bus.REFUND = 1'b1; step(); @(negedge clk);
        chk("ign_credit", 32'(bus.credit), 4); chk("ign_rpls", 32'(bus.refund_pls), 0);
        step(); @(negedge clk);
        chk("ign_busy", 32'(bus.busy), 0);

        // Coin 0 and vend 0 leave credit unchanged
        op(1'b1, 4'd0, 1'b0, 4'd0, 1'b0); step(); step(); @(negedge clk);
        chk("c0_credit", 32'(bus.credit), 4); chk("c0_ovf", 32'(bus.ovf), 0);
        op(1'b0, 4'd0, 1'b1, 4'd0, 1'b0); step(); step(); @(negedge clk);
        chk("v0_credit", 32'(bus.credit), 4); chk("v0_disp", 32'(bus.dispense), 1);

        // Reset during STROBE aborts the vend
        op(1'b0, 4'd0, 1'b1, 4'd2, 1'b0); step(); @(negedge clk);
        chk("abort_ENTER_pre", 32'(bus.ENTER), 1);
        #2 CLR_n = 1'b0;
        model_reset();
        #1;
        chk("abort_ENTER", 32'(bus.ENTER), 0); chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_credit", 32'(bus.credit), 0); chk("abort_A", 32'(bus.A), 0);
        step(); @(negedge clk);
        CLR_n = 1'b1;
        step(); step(); step(); @(negedge clk);
        chk("abort_disp", 32'(bus.dispense), 0); chk("abort_credit2", 32'(bus.credit), 0);

        // Saturation boundary: 0+15 exact, 15+1 overflows, vend 15 empties
        op(1'b1, 4'd15, 1'b0, 4'd0, 1'b0); step(); step(); @(negedge clk);
        chk("c15_credit", 32'(bus.credit), 15); chk("c15_ovf", 32'(bus.ovf), 0);
        op(1'b1, 4'd1, 1'b0, 4'd0, 1'b0); step(); step(); @(negedge clk);
        chk("c16_credit", 32'(bus.credit), 15); chk("c16_ovf", 32'(bus.ovf), 1);
        op(1'b0, 4'd0, 1'b1, 4'd15, 1'b0); step(); step(); @(negedge clk);
        chk("v15_credit", 32'(bus.credit), 0); chk("v15_disp", 32'(bus.dispense), 1);

        repeat (3) step();
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/credit_sequencer.md
CREDIT_SEQUENCER -- requirements
Module: credit_sequencer

Interface
- REQ-001: Parameter CREDIT_MAX, default 15, SHALL be the saturation limit for stored credit (at most 15).
- REQ-002: clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
- REQ-003: CLR_n  input  1  SHALL be the reset: asynchronous, active-low.
- REQ-004: COIN  input  1  SHALL be a one-cycle coin-inserted pulse (debounced upstream).
- REQ-005: COIN_VAL  input  4  SHALL be the value of the inserted coin, sampled with COIN.
- REQ-006: VEND  input  1  SHALL be a one-cycle purchase-request pulse.
- REQ-007: PRICE  input  4  SHALL be the item price, sampled with VEND.
- REQ-008: REFUND  input  1  SHALL be a one-cycle refund-request pulse.
- REQ-009: A, B  output  4 each  SHALL be the operands driven to the adder_sub display datapath.
- REQ-010: SUB  output  1  SHALL select the adder_sub operation (0 = add, 1 = subtract).
- REQ-011: ENTER  output  1  SHALL be the one-cycle strobe telling adder_sub that A/B/SUB are valid.
- REQ-012: credit  output  4  SHALL be the current stored credit.
- REQ-013: busy  output  1  SHALL be high while an operation is in flight.
- REQ-014: dispense, deny, refund_pls, ovf  output  1 each  SHALL be one-cycle status pulses.
- REQ-015: refund_val  output  4  SHALL hold the amount returned; it is valid when refund_pls is high.

Function
- REQ-016: The FSM SHALL have three states, IDLE, SETUP and STROBE, and SHALL sequence IDLE -> SETUP -> STROBE -> IDLE.
- REQ-017: In IDLE only, the block SHALL sample requests with priority REFUND > VEND > COIN; a lower-priority request in the same cycle SHALL be dropped.
- REQ-018: All requests arriving while busy=1 SHALL be ignored and SHALL NOT be queued.
- REQ-019: When a request is accepted at edge N:
  - A, B and SUB SHALL be registered and stable from N+1.
  - The state SHALL be SETUP during N+1 and STROBE during N+2.
  - ENTER SHALL be high for exactly the N+2 cycle.
  - busy SHALL be high for the N+1 and N+2 cycles.
  - credit and the status pulses SHALL update at edge N+3, with the pulses high for exactly one cycle.
- REQ-020: A, B and SUB SHALL hold their last values while in IDLE, so the display shows the last operation.
- REQ-021: COIN SHALL drive A=credit, B=COIN_VAL, SUB=0, and set the new credit to min(credit+COIN_VAL, CREDIT_MAX); ovf SHALL pulse when the 5-bit sum exceeds CREDIT_MAX.
- REQ-022: COIN with COIN_VAL=0 SHALL still run the full sequence and leave credit unchanged.
- REQ-023: VEND with credit >= PRICE SHALL drive A=credit, B=PRICE, SUB=1, then set credit=credit-PRICE and pulse dispense.
- REQ-024: VEND with credit < PRICE SHALL NOT enter SETUP, SHALL NOT assert ENTER or busy, SHALL pulse deny at edge N+1, and SHALL leave credit unchanged.
- REQ-025: VEND with PRICE=0 SHALL dispense, leaving credit unchanged.
- REQ-026: REFUND SHALL drive A=credit, B=credit, SUB=1, then set credit=0, refund_val=old credit, and pulse refund_pls; this SHALL apply even when credit is 0.
- REQ-027: Arithmetic SHALL be performed at 5 bits internally; credit SHALL never wrap.

Reset
- REQ-028: CLR_n=0 SHALL immediately force state=IDLE and set A, B, SUB, ENTER, credit, busy, dispense, deny, refund_pls, ovf and refund_val all to 0.
- REQ-029: Reset asserted mid-operation SHALL abort the operation: no ENTER, no status pulse, and no credit update.
- REQ-030: After CLR_n is released, the first request SHALL be accepted on the next rising edge.

Verification
- REQ-031: Reset, then COIN with COIN_VAL=5 -> A=0, B=5, SUB=0 at N+1; ENTER at N+2; credit=5 at N+3; busy high for exactly 2 cycles.
- REQ-032: With credit=12, COIN with COIN_VAL=6 -> A=12, B=6; credit=15; ovf pulses for 1 cycle.
- REQ-033: With credit=6, VEND with PRICE=5 -> A=6, B=5, SUB=1, ENTER; credit=1; dispense pulses. Then VEND with PRICE=8 -> deny pulses, no ENTER, credit stays 1.
- REQ-034: COIN, VEND and REFUND all in the same IDLE cycle with credit=7 -> REFUND wins; credit=0, refund_val=7; no dispense, no coin added.
- REQ-035: COIN pulsed during SETUP -> ignored; credit reflects only the first operation.
- REQ-036: CLR_n pulled low during STROBE with credit=4 -> ENTER deasserts immediately; all outputs 0; no status pulse after release.
